fadd16_sched: RTL and testbench

Round-robin scheduler that shares one 16-bit floating-point adder among `NREQ` requesters. It accepts operand pairs plus rounding mode over per-requester valid/ready handshakes and drives the adder's operand and rounding-mode inputs from registers. It tracks each in-flight operation's requester ID through a tag pipeline matched to the adder latency, and returns tagged sums. A drain/idle FSM lets upper-level control quiesce the shared adder, for example before reconfiguration or a clock gate.

---
 rtl/fadd16_sched_pkg.sv | 26 ++
 rtl/fadd16_rr_arb.sv | 36 +++
 rtl/fadd16_sched.sv | 119 +++++++++++
 tb/tb_fadd16_sched.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fadd16_sched_pkg.sv
// Shared types for the fp16 adder scheduler: rounding modes, FSM states and
// the requester tag width.
package fadd16_sched_pkg;

  // Rounding modes seen by the shared adder; RNE is the reset/default mode.
  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } fpu_rounding_mode_t;

  // Scheduler FSM: RUN issues, DRAIN waits for in-flight work, IDLE is parked.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } fadd16_sched_state_t;

  // Width of a requester ID carried through the tag pipe.
  function automatic int FADD16_TAG_W(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/fadd16_rr_arb.sv
// Combinational round-robin arbiter: the search starts one past ptr and
// returns a one-hot grant plus the encoded winner.
module fadd16_rr_arb
  import fadd16_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]                 req,
  input  logic [FADD16_TAG_W(NREQ)-1:0]   ptr,
  input  logic                            en,
  output logic [NREQ-1:0]                 gnt,
  output logic [FADD16_TAG_W(NREQ)-1:0]   gnt_id
);

  localparam int ID_W = FADD16_TAG_W(NREQ);

  logic found;
  int   idx;

  // Walk ptr+1, ptr+2, ... ptr (mod NREQ) and take the first asserted request.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fadd16_sched.sv
// Shares one fp16 adder among NREQ requesters: round-robin issue, registered
// adder operands, an ID tag pipe matched to the adder latency, tagged responses
// and a RUN/DRAIN/IDLE quiesce FSM.
module fadd16_sched
  import fadd16_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NREQ-1:0]                          req_valid,
  output logic [NREQ-1:0]                          req_ready,
  input  logic [NREQ*16-1:0]                       req_float1,
  input  logic [NREQ*16-1:0]                       req_float2,
  input  logic [NREQ*$bits(fpu_rounding_mode_t)-1:0] req_rm,
  input  logic                                     drain_req,
  output logic                                     idle,
  output logic [15:0]                              add_float1,
  output logic [15:0]                              add_float2,
  output fpu_rounding_mode_t                       add_rm,
  input  logic [15:0]                              add_sum,
  output logic                                     rsp_valid,
  output logic [FADD16_TAG_W(NREQ)-1:0]            rsp_id,
  output logic [15:0]                              rsp_sum,
  output fadd16_sched_state_t                      dbg_state
);

  localparam int ID_W = FADD16_TAG_W(NREQ);
  localparam int RM_W = $bits(fpu_rounding_mode_t);

  // Handshake: requester i transfers on a cycle where req_valid[i] and
  // req_ready[i] are both high at the rising edge. req_ready never depends on
  // anything registered except state and ptr, and is at most one-hot. A waiting
  // requester must hold its operands stable. Responses have no backpressure.

  fadd16_sched_state_t state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     win_id;
  logic [NREQ-1:0]     gnt;
  logic                arb_en;
  logic                xfer;
  logic [ADD_LAT:0]    tag_v;
  logic [ID_W-1:0]     tag_id [ADD_LAT+1];

  // drain_req masks grants in the same cycle; reset also masks them.
  assign arb_en = !rst && (state == ST_RUN) && !drain_req;

  fadd16_rr_arb #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (win_id)
  );

  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);
  assign idle      = (state == ST_IDLE);
  assign dbg_state = state;

  // Quiesce FSM: leave DRAIN only once no tag or response is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (drain_req) state <= ST_DRAIN;
        ST_DRAIN: if (!(|tag_v) && !rsp_valid) state <= ST_IDLE;
        ST_IDLE:  if (!drain_req) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  // Capture the winner's operands and advance the pointer on each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= ID_W'(NREQ - 1);
      add_float1 <= '0;
      add_float2 <= '0;
      add_rm     <= RNE;
    end else if (xfer) begin
      ptr        <= win_id;
      add_float1 <= req_float1[16*int'(win_id) +: 16];
      add_float2 <= req_float2[16*int'(win_id) +: 16];
      add_rm     <= fpu_rounding_mode_t'(req_rm[RM_W*int'(win_id) +: RM_W]);
    end
  end

  // Tag shift pipe, one stage per adder cycle plus the operand register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int i = 0; i <= ADD_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= xfer;
      tag_id[0] <= win_id;
      for (int i = 1; i <= ADD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // Response register: pairs the last tag with the adder result of that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
    end else begin
      rsp_valid <= tag_v[ADD_LAT];
      rsp_id    <= tag_id[ADD_LAT];
      rsp_sum   <= add_sum;
    end
  end

endmodule

// File: tb/tb_fadd16_sched.sv
// Bench for fadd16_sched with a behavioural fp16 adder (positive operands)
// followed by an ADD_LAT-deep delay line.
module tb_fadd16_sched;
  import fadd16_sched_pkg::*;

  localparam int NREQ    = 4;
  localparam int ADD_LAT = 2;
  localparam int IDW     = FADD16_TAG_W(NREQ);
  localparam int RMW     = $bits(fpu_rounding_mode_t);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*16-1:0]    req_float1;
  logic [NREQ*16-1:0]    req_float2;
  logic [NREQ*RMW-1:0]   req_rm;
  logic                  drain_req;
  logic                  idle;
  logic [15:0]           add_float1;
  logic [15:0]           add_float2;
  fpu_rounding_mode_t    add_rm;
  logic [15:0]           add_sum;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [15:0]           rsp_sum;
  fadd16_sched_state_t   dbg_state;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  logic [35:0] exp_q[$];
  logic [15:0] cur_exp [NREQ];

  typedef struct {
    int                 id;
    logic [15:0]        a;
    logic [15:0]        b;
    fpu_rounding_mode_t rm;
    logic [15:0]        sum;
  } vec_t;
  vec_t vecs [9];

  fadd16_sched #(.NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_float1 (req_float1),
    .req_float2 (req_float2),
    .req_rm     (req_rm),
    .drain_req  (drain_req),
    .idle       (idle),
    .add_float1 (add_float1),
    .add_float2 (add_float2),
    .add_rm     (add_rm),
    .add_sum    (add_sum),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- adder stand-in ----------------
  // Add two positive finite fp16 values with proper guard/sticky rounding.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b,
                                           input fpu_rounding_mode_t rm);
    logic [4:0]  ea, eb, et;
    logic [10:0] ma, mb, mt;
    logic [63:0] xa, xb, s;
    logic [11:0] sig;
    logic [40:0] rem;
    logic [5:0]  e;
    logic        up;
    int          d;
    ea = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    eb = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    ma = {|a[14:10], a[9:0]};
    mb = {|b[14:10], b[9:0]};
    if (eb > ea) begin
      et = ea; ea = eb; eb = et;
      mt = ma; ma = mb; mb = mt;
    end
    d  = int'(ea) - int'(eb);
    xa = {53'b0, ma} << 40;
    xb = ({53'b0, mb} << 40) >> d;
    s  = xa + xb;
    if (s[51]) begin
      sig = {1'b0, s[51:41]};
      rem = s[40:0];
      e   = {1'b0, ea} + 6'd1;
    end else begin
      sig = {1'b0, s[50:40]};
      rem = {s[39:0], 1'b0};
      e   = {1'b0, ea};
    end
    case (rm)
      RNE:     up = rem[40] && ((|rem[39:0]) || sig[0]);
      RUP:     up = |rem;
      RMM:     up = rem[40];
      default: up = 1'b0;
    endcase
    sig = sig + {11'b0, up};
    if (sig[11]) begin
      sig = sig >> 1;
      e   = e + 6'd1;
    end
    return {1'b0, sig[10] ? e[4:0] : 5'd0, sig[9:0]};
  endfunction

  logic [15:0] sum_c;
  assign sum_c = fp16_add(add_float1, add_float2, add_rm);

  generate
    if (ADD_LAT == 0) begin : g_comb
      assign add_sum = sum_c;
    end else begin : g_dly
      logic [15:0] dly [ADD_LAT];
      always @(posedge clk) begin
        dly[0] <= sum_c;
        for (int i = 1; i < ADD_LAT; i++) dly[i] <= dly[i-1];
      end
      assign add_sum = dly[ADD_LAT-1];
    end
  endgenerate

  // ---------------- requester protocol check ----------------
  logic [NREQ-1:0]     prev_v, prev_r;
  logic [NREQ*16-1:0]  prev_f1, prev_f2;
  logic [NREQ*RMW-1:0] prev_rm;
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (prev_v[i] && !prev_r[i] && req_valid[i] &&
            (req_float1[i*16 +: 16] != prev_f1[i*16 +: 16] ||
             req_float2[i*16 +: 16] != prev_f2[i*16 +: 16] ||
             req_rm[i*RMW +: RMW]   != prev_rm[i*RMW +: RMW]))
          $error("requester %0d changed operands while waiting for a grant", i);
      end
    end
    prev_v  <= rst ? '0 : req_valid;
    prev_r  <= req_ready;
    prev_f1 <= req_float1;
    prev_f2 <= req_float2;
    prev_rm <= req_rm;
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [35:0] e;
    if (rsp_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d sum=%h at cycle %0d, required no response",
                 rsp_id, rsp_sum, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({16'(cyc), 4'(rsp_id), rsp_sum} !== e) begin
          n_fail++;
          $display("FAIL rsp_match: got cycle=%0d id=%0d sum=%h, required cycle=%0d id=%0d sum=%h",
                   cyc, rsp_id, rsp_sum, e[35:20], e[19:16], e[15:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int id);
    exp_q.push_back({16'(cyc + 2 + ADD_LAT), 4'(id), cur_exp[id]});
  endtask

  // Record any transfer in the current cycle, then move to the next cycle.
  task automatic step();
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) push_exp(i);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                         input fpu_rounding_mode_t rm);
    req_float1[id*16 +: 16] = a;
    req_float2[id*16 +: 16] = b;
    req_rm[id*RMW +: RMW]   = rm;
  endtask

  task automatic set_rr_ops();
    set_req(0, 16'h3C00, 16'h3C00, RNE);
    set_req(1, 16'h3C00, 16'h4000, RNE);
    set_req(2, 16'h4000, 16'h4000, RNE);
    set_req(3, 16'h3C00, 16'h3800, RNE);
    cur_exp[0] = 16'h4000;
    cur_exp[1] = 16'h4200;
    cur_exp[2] = 16'h4400;
    cur_exp[3] = 16'h3E00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  32'(req_ready),  32'd0);
    check({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    check({tag, "_rsp_id"},     32'(rsp_id),     32'd0);
    check({tag, "_rsp_sum"},    32'(rsp_sum),    32'd0);
    check({tag, "_add_float1"}, 32'(add_float1), 32'd0);
    check({tag, "_add_float2"}, 32'(add_float2), 32'd0);
    check({tag, "_add_rm"},     32'(add_rm),     32'(RNE));
    check({tag, "_idle"},       32'(idle),       32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t3;
    int wait_n;
    logic got;

    vecs[0] = '{2, 16'h3C00, 16'h4000, RNE, 16'h4200};
    vecs[1] = '{1, 16'h3C00, 16'h0001, RNE, 16'h3C00};
    vecs[2] = '{2, 16'h3C00, 16'h0001, RUP, 16'h3C01};
    vecs[3] = '{0, 16'h3C00, 16'h3C00, RNE, 16'h4000};
    vecs[4] = '{3, 16'h4000, 16'h4000, RNE, 16'h4400};
    vecs[5] = '{1, 16'h3C00, 16'h3800, RNE, 16'h3E00};
    vecs[6] = '{0, 16'h3C00, 16'h1000, RNE, 16'h3C00};
    vecs[7] = '{3, 16'h3C01, 16'h1000, RNE, 16'h3C02};
    vecs[8] = '{1, 16'h3C00, 16'h1000, RUP, 16'h3C01};

    rst        = 1'b1;
    drain_req  = 1'b0;
    req_valid  = '0;
    req_float1 = '0;
    req_float2 = '0;
    req_rm     = '0;
    set_rr_ops();
    req_valid  = '1;

    // Reset values with every requester asking.
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    // Round robin from reset: 0,1,2,3,0,1,2,3 and responses in that order.
    rst = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("rr_grant", 32'(req_ready), 32'(1 << (k % NREQ)));
      step();
    end
    req_valid = '0;
    idle_cycles(12);
    check("rr_all_rsp", 32'(exp_q.size()), 32'd0);

    // Directed single-request vectors.
    for (int v = 0; v < 9; v++) begin
      set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].rm);
      cur_exp[vecs[v].id] = vecs[v].sum;
      req_valid = NREQ'(1) << vecs[v].id;
      #1;
      check("vec_grant", 32'(req_ready), 32'(1 << vecs[v].id));
      step();
      req_valid = '0;
      idle_cycles(6);
    end
    check("vec_all_rsp", 32'(exp_q.size()), 32'd0);

    // Starvation: requester 0 always valid, requester 3 must still win soon.
    set_rr_ops();
    req_valid = 4'b0001;
    #1;
    repeat (3) begin
      check("starv_r0_grant", 32'(req_ready), 32'd1);
      step();
    end
    req_valid = 4'b1001;
    #1;
    got    = 1'b0;
    wait_n = 0;
    while (!got && wait_n < NREQ) begin
      got = req_ready[3];
      step();
      wait_n++;
    end
    check("starv_r3_granted", 32'(got), 32'd1);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    idle_cycles(10);
    check("starv_all_rsp", 32'(exp_q.size()), 32'd0);

    // Drain with three ops in flight and requester 1 pending.
    req_valid = 4'b0001;
    #1;
    check("drain_iss0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0100;
    #1;
    check("drain_iss1", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b1000;
    #1;
    check("drain_iss2", 32'(req_ready), 32'b1000);
    t3 = cyc;
    step();
    req_valid = 4'b0010;
    drain_req = 1'b1;
    #1;
    while (cyc < t3 + 2 + ADD_LAT + 2) begin
      check("drain_mask", 32'(req_ready), 32'd0);
      step();
    end
    check("drain_idle", 32'(idle), 32'd1);
    check("drain_all_rsp", 32'(exp_q.size()), 32'd0);
    drain_req = 1'b0;
    #1;
    check("idle_mask", 32'(req_ready), 32'd0);
    step();
    check("resume_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    idle_cycles(8);
    check("resume_rsp", 32'(exp_q.size()), 32'd0);

    // Drain with nothing in flight: idle two cycles after drain_req rises.
    drain_req = 1'b1;
    step();
    check("empty_drain_t1", 32'(idle), 32'd0);
    step();
    check("empty_drain_t2", 32'(idle), 32'd1);
    drain_req = 1'b0;
    step();
    check("empty_drain_run", 32'(idle), 32'd0);

    // Reset with two ops in flight: no responses, first grant to requester 0.
    req_valid = 4'b0010;
    #1;
    step();
    req_valid = 4'b0100;
    #1;
    step();
    rst = 1'b1;
    exp_q.delete();
    req_valid = 4'b0111;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    idle_cycles(10);
    check("post_rst_rsp", 32'(exp_q.size()), 32'd0);

    // Two requesters, same operands, different rounding modes.
    set_req(1, 16'h3C00, 16'h0001, RNE);
    set_req(2, 16'h3C00, 16'h0001, RUP);
    cur_exp[1] = 16'h3C00;
    cur_exp[2] = 16'h3C01;
    req_valid = 4'b0110;
    #1;
    check("rm_grant1", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0100;
    #1;
    check("rm_grant2", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    idle_cycles(8);
    check("rm_all_rsp", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
